// File: rtl/area_class_ctrl.sv
// Round-robin per-frame area measurement over NUM_CLASSES colour masks, followed by a
// largest-area decision. Define AREA_CLASS_CTRL_CONTINUOUS_EN to repeat decisions after each ack.
module area_class_ctrl #(
  parameter int NUM_CLASSES  = 4,
  parameter int SEL_W        = 2,
  parameter int AREA_W       = 24,
  parameter int MIN_AREA     = 1000,
  parameter bit ACTIVE_LEVEL = 1'b0
) (
  input  logic              pixelclk,
  input  logic              rst,
  input  logic              start,
  input  logic              i_vs,
  input  logic              i_hs,
  input  logic              i_de,
  input  logic              i_binary,
  output logic [SEL_W-1:0]  mask_sel,
  output logic              busy,
  output logic              area_valid,
  output logic [AREA_W-1:0] area_out,
  output logic [SEL_W-1:0]  area_idx,
  output logic              result_valid,
  output logic [SEL_W-1:0]  result_class,
  output logic [AREA_W-1:0] result_area,
  output logic              no_object,
  input  logic              result_ack
);

  typedef enum logic [2:0] {IDLE, SYNC, MEAS, DECIDE, RESULT} state_t;

  localparam int CMP_W = (AREA_W > 31) ? AREA_W + 1 : 32;

  state_t              state;
  state_t              state_nxt;
  logic                vs_d;
  logic                hs_d;
  logic                unused_hs;
  logic                vs_fall;
  logic                pixel_hit;
  logic                last_class;
  logic                last_scan;
  logic [AREA_W-1:0]   count;
  logic [AREA_W-1:0]   bank [NUM_CLASSES];
  logic [SEL_W-1:0]    scan_idx;
  logic [AREA_W-1:0]   max_area;
  logic [SEL_W-1:0]    max_idx;
  logic [AREA_W-1:0]   cand;
  logic                cand_gt;
  logic [AREA_W-1:0]   win_area;
  logic [SEL_W-1:0]    win_idx;
  logic                win_noobj;

  // hs is kept only for timing alignment with vs; de alone qualifies pixels
  assign unused_hs  = hs_d;
  assign vs_fall    = vs_d & ~i_vs;
  assign pixel_hit  = i_de && (i_binary == ACTIVE_LEVEL);
  assign last_class = (mask_sel == SEL_W'(NUM_CLASSES - 1));
  assign last_scan  = (scan_idx == SEL_W'(NUM_CLASSES - 1));

  // Strictly-greater replacement keeps the lowest index on ties
  assign cand      = bank[scan_idx];
  assign cand_gt   = (cand > max_area);
  assign win_area  = cand_gt ? cand : max_area;
  assign win_idx   = cand_gt ? scan_idx : max_idx;
  assign win_noobj = ({{(CMP_W - AREA_W){1'b0}}, win_area} < CMP_W'(MIN_AREA));

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SYNC;
      SYNC:    if (vs_fall) state_nxt = MEAS;
      MEAS:    if (vs_fall && last_class) state_nxt = DECIDE;
      DECIDE:  if (last_scan) state_nxt = RESULT;
      RESULT: begin
        if (result_ack) begin
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
          state_nxt = SYNC;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == RESULT);
  end

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      vs_d         <= 1'b0;
      hs_d         <= 1'b0;
      mask_sel     <= '0;
      count        <= '0;
      area_valid   <= 1'b0;
      area_out     <= '0;
      area_idx     <= '0;
      scan_idx     <= '0;
      max_area     <= '0;
      max_idx      <= '0;
      result_class <= '0;
      result_area  <= '0;
      no_object    <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        bank[i] <= '0;
      end
    end else begin
      vs_d       <= i_vs;
      hs_d       <= i_hs;
      area_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) mask_sel <= '0;
        end
        SYNC: begin
          if (vs_fall) count <= '0;
        end
        MEAS: begin
          if (vs_fall) begin
            bank[mask_sel] <= count;
            count          <= '0;
            area_valid     <= 1'b1;
            area_out       <= count;
            area_idx       <= mask_sel;
            if (last_class) begin
              scan_idx <= '0;
              max_area <= '0;
              max_idx  <= '0;
            end else begin
              mask_sel <= mask_sel + 1'b1;
            end
          end else if (pixel_hit && (count != '1)) begin
            count <= count + 1'b1;
          end
        end
        DECIDE: begin
          max_area <= win_area;
          max_idx  <= win_idx;
          scan_idx <= scan_idx + 1'b1;
          if (last_scan) begin
            result_class <= win_noobj ? '0 : win_idx;
            result_area  <= win_area;
            no_object    <= win_noobj;
          end
        end
        RESULT: begin
          if (result_ack) mask_sel <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_area_class_ctrl.sv
// Randomised scoreboard bench for area_class_ctrl: frames with known object-pixel counts,
// expected areas/decisions queued by a behavioural model and checked by an output monitor.
module tb_area_class_ctrl;

  localparam int NUM_CLASSES  = 4;
  localparam int SEL_W        = 2;
  localparam int AREA_W       = 5;
  localparam int MIN_AREA     = 8;
  localparam bit ACTIVE_LEVEL = 1'b0;
  localparam int LINE_W       = 8;
  localparam int AREA_MAX     = (1 << AREA_W) - 1;

  logic              pixelclk;
  logic              rst;
  logic              start;
  logic              i_vs;
  logic              i_hs;
  logic              i_de;
  logic              i_binary;
  logic [SEL_W-1:0]  mask_sel;
  logic              busy;
  logic              area_valid;
  logic [AREA_W-1:0] area_out;
  logic [SEL_W-1:0]  area_idx;
  logic              result_valid;
  logic [SEL_W-1:0]  result_class;
  logic [AREA_W-1:0] result_area;
  logic              no_object;
  logic              result_ack;

  area_class_ctrl #(
    .NUM_CLASSES (NUM_CLASSES),
    .SEL_W       (SEL_W),
    .AREA_W      (AREA_W),
    .MIN_AREA    (MIN_AREA),
    .ACTIVE_LEVEL(ACTIVE_LEVEL)
  ) dut (
    .pixelclk    (pixelclk),
    .rst         (rst),
    .start       (start),
    .i_vs        (i_vs),
    .i_hs        (i_hs),
    .i_de        (i_de),
    .i_binary    (i_binary),
    .mask_sel    (mask_sel),
    .busy        (busy),
    .area_valid  (area_valid),
    .area_out    (area_out),
    .area_idx    (area_idx),
    .result_valid(result_valid),
    .result_class(result_class),
    .result_area (result_area),
    .no_object   (no_object),
    .result_ack  (result_ack)
  );

  initial pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  typedef struct {
    int area;
    int idx;
  } area_exp_t;

  typedef struct {
    int cls;
    int area;
    int noobj;
  } res_exp_t;

  area_exp_t area_q[$];
  res_exp_t  result_q[$];
  area_exp_t mon_area;
  res_exp_t  mon_res;
  logic      rv_prev;
  int        checks;
  int        failures;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int a);
    return (a > AREA_MAX) ? AREA_MAX : a;
  endfunction

  // Reference decision: first class holding the largest saturated area wins
  function automatic res_exp_t decide(input int a[NUM_CLASSES]);
    res_exp_t r;
    int best;
    best  = -1;
    r.cls = 0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (sat(a[i]) > best) begin
        best  = sat(a[i]);
        r.cls = i;
      end
    end
    r.area  = best;
    r.noobj = (best < MIN_AREA) ? 1 : 0;
    if (r.noobj != 0) r.cls = 0;
    return r;
  endfunction

  // Monitor: every captured area and every new decision is popped and compared
  always @(negedge pixelclk) begin
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      if (area_valid) begin
        if (area_q.size() == 0) begin
          checkOutput("area_unexpected", 1, 0);
        end else begin
          mon_area = area_q.pop_front();
          checkOutput("area_out", area_out, mon_area.area);
          checkOutput("area_idx", area_idx, mon_area.idx);
        end
      end
      if (result_valid && !rv_prev) begin
        if (result_q.size() == 0) begin
          checkOutput("result_unexpected", 1, 0);
        end else begin
          mon_res = result_q.pop_front();
          checkOutput("result_class", result_class, mon_res.cls);
          checkOutput("result_area", result_area, mon_res.area);
          checkOutput("no_object", no_object, mon_res.noobj);
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic vsPulse();
    i_de     = 1'b0;
    i_hs     = 1'b0;
    i_binary = ACTIVE_LEVEL;
    i_vs     = 1'b1;
    repeat (3) tick();
    i_vs = 1'b0;
    repeat (2) tick();
  endtask

  // One frame of `lines` x LINE_W pixels with exactly `target` object pixels at random places;
  // start pulses once `start_after` object pixels have gone by (negative: never)
  task automatic applyStimulus(input int lines, input int target, input int start_after);
    int slots;
    int placed;
    bit started;
    bit hit;
    slots   = lines * LINE_W;
    placed  = 0;
    started = 1'b0;
    vsPulse();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < LINE_W; p++) begin
        start = (start_after >= 0) && !started && (placed >= start_after);
        if (start) started = 1'b1;
        hit      = (int'($urandom_range(0, slots - 1)) < (target - placed));
        i_de     = 1'b1;
        i_hs     = 1'b0;
        i_binary = hit ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
        if (hit) placed++;
        slots--;
        tick();
      end
      start    = 1'b0;
      i_de     = 1'b0;
      i_hs     = 1'b1;
      i_binary = ACTIVE_LEVEL;
      repeat (2) tick();
      i_hs = 1'b0;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_mask_sel"}, mask_sel, 0);
    checkOutput({pfx, "_area_valid"}, area_valid, 0);
    checkOutput({pfx, "_area_out"}, area_out, 0);
    checkOutput({pfx, "_area_idx"}, area_idx, 0);
    checkOutput({pfx, "_result_valid"}, result_valid, 0);
    checkOutput({pfx, "_result_class"}, result_class, 0);
    checkOutput({pfx, "_result_area"}, result_area, 0);
    checkOutput({pfx, "_no_object"}, no_object, 0);
  endtask

  task automatic resetDut(input bit check);
    rst        = 1'b1;
    start      = 1'b0;
    i_vs       = 1'b0;
    i_hs       = 1'b0;
    i_de       = 1'b0;
    i_binary   = ~ACTIVE_LEVEL;
    result_ack = 1'b0;
    repeat (3) tick();
    if (check) checkIdle("reset");
    area_q.delete();
    result_q.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic ackResult();
    int n;
    n = 0;
    while (!result_valid && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("result_timeout", result_valid, 1);
    repeat ($urandom_range(1, 4)) tick();
    checkOutput("result_held", result_valid, 1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checkOutput("result_cleared", result_valid, 0);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    checkOutput("busy_after_ack", busy, 1);
    checkOutput("mask_sel_after_ack", mask_sel, 0);
`else
    checkOutput("busy_after_ack", busy, 0);
`endif
  endtask

  task automatic runDecision(input int a[NUM_CLASSES], input int lines,
                             input bit start_in_decide, input bit issue_start);
    area_exp_t e;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      e.area = sat(a[i]);
      e.idx  = i;
      area_q.push_back(e);
    end
    result_q.push_back(decide(a));
    if (issue_start) begin
      pulseStart();
      checkOutput("busy_after_start", busy, 1);
    end
    for (int i = 0; i < NUM_CLASSES; i++) begin
      applyStimulus(lines, a[i], -1);
    end
    vsPulse();
    if (start_in_decide) pulseStart();
    ackResult();
  endtask

  initial begin
    int a[NUM_CLASSES];
    area_exp_t e;
    checks   = 0;
    failures = 0;
    rv_prev  = 1'b0;
    resetDut(1'b1);

    $display("[TB] single decision");
    a = '{10, 25, 5, 25};
    runDecision(a, 4, 1'b0, 1'b1);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    $display("[TB] continuous repeat without start");
    a = '{4, 9, 30, 12};
    runDecision(a, 4, 1'b0, 1'b0);
    resetDut(1'b0);
`endif

    $display("[TB] no object");
    a = '{3, 2, 7, 0};
    runDecision(a, 4, 1'b0, 1'b1);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    resetDut(1'b0);
`endif

    $display("[TB] mid-frame start");
    applyStimulus(4, 20, 12);
    a = '{4, 9, 9, 1};
    runDecision(a, 4, 1'b0, 1'b0);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    resetDut(1'b0);
`endif

    $display("[TB] saturation");
    a = '{40, 3, 0, 12};
    runDecision(a, 5, 1'b0, 1'b1);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    resetDut(1'b0);
`endif

    $display("[TB] abort during measurement");
    pulseStart();
    for (int i = 0; i < 2; i++) begin
      e.area = 6 + i;
      e.idx  = i;
      area_q.push_back(e);
      applyStimulus(4, 6 + i, -1);
    end
    vsPulse();
    i_de     = 1'b1;
    i_binary = ACTIVE_LEVEL;
    repeat (5) tick();
    checkOutput("abort_mask_sel", mask_sel, 2);
    checkOutput("abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1 checkIdle("abort");
    checkOutput("abort_areas_drained", area_q.size(), 0);
    resetDut(1'b0);

    $display("[TB] start during decide");
    a = '{17, 17, 2, 31};
    runDecision(a, 4, 1'b1, 1'b1);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
    resetDut(1'b0);
`endif

    $display("[TB] random decisions");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 12 : int'($urandom_range(0, 32));
      end
      runDecision(a, 4, 1'b0, 1'b1);
`ifdef AREA_CLASS_CTRL_CONTINUOUS_EN
      resetDut(1'b0);
`endif
    end

    repeat (5) tick();
    checkOutput("areas_drained", area_q.size(), 0);
    checkOutput("results_drained", result_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
